// File: rtl/pwm_array.sv
// Multi-channel PWM generator sharing one counter, with shadowed duty/period registers
// that take effect only at period boundaries. Define PWM_ARRAY_CENTER_EN for center-aligned mode.
module pwm_array #(
  parameter int R_SIZE = 8,
  parameter int CH     = 4,
  localparam int CSW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load,
  input  logic [CSW-1:0]    ch_sel,
  input  logic [R_SIZE-1:0] duty,
  input  logic              load_period,
  input  logic [R_SIZE-1:0] period,
  input  logic              mode,
  output logic [CH-1:0]     pwm,
  output logic              cycle_start
);

  logic [R_SIZE-1:0] cnt;
  logic [R_SIZE-1:0] cnt_n;
  logic [R_SIZE-1:0] act_p;
  logic [R_SIZE-1:0] shd_p;
  logic [R_SIZE-1:0] eff_p;
  logic [R_SIZE-1:0] act_duty [CH];
  logic [R_SIZE-1:0] shd_duty [CH];
  logic [CH-1:0]     pwm_n;
  logic              boundary;

  // The counter sits at 0 exactly once per period, and also while disabled,
  // so the first enabled cycle after reset or re-enable is a boundary too.
  assign boundary = enable && (cnt == {R_SIZE{1'b0}});
  // In the boundary cycle the new period already runs on the shadow values.
  assign eff_p    = boundary ? shd_p : act_p;

  // Shadow registers: written at any time, even while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shd_p <= {R_SIZE{1'b0}};
      for (int i = 0; i < CH; i++) shd_duty[i] <= {R_SIZE{1'b0}};
    end else begin
      if (load_period) shd_p <= period;
      for (int i = 0; i < CH; i++) begin
        if (load && (ch_sel == CSW'(i))) shd_duty[i] <= duty;
      end
    end
  end

  // Active registers: copied from the shadows at each boundary only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_p <= {R_SIZE{1'b0}};
      for (int i = 0; i < CH; i++) act_duty[i] <= {R_SIZE{1'b0}};
    end else if (boundary) begin
      act_p <= shd_p;
      for (int i = 0; i < CH; i++) act_duty[i] <= shd_duty[i];
    end
  end

`ifdef PWM_ARRAY_CENTER_EN
  logic act_mode;
  logic eff_mode;
  logic dir_down;
  logic dir_down_n;

  assign eff_mode = boundary ? mode : act_mode;

  // Next count: edge wraps after P; center turns around at P and returns to 0.
  always_comb begin
    cnt_n      = cnt;
    dir_down_n = dir_down;
    if (!enable || (eff_p == {R_SIZE{1'b0}})) begin
      cnt_n      = {R_SIZE{1'b0}};
      dir_down_n = 1'b0;
    end else if (eff_mode) begin
      if (!dir_down) begin
        if (cnt == eff_p) begin
          cnt_n      = eff_p - R_SIZE'(1);
          dir_down_n = (eff_p != R_SIZE'(1));
        end else begin
          cnt_n      = cnt + R_SIZE'(1);
          dir_down_n = 1'b0;
        end
      end else begin
        cnt_n      = cnt - R_SIZE'(1);
        dir_down_n = (cnt != R_SIZE'(1));
      end
    end else begin
      cnt_n      = (cnt == eff_p) ? {R_SIZE{1'b0}} : cnt + R_SIZE'(1);
      dir_down_n = 1'b0;
    end
  end

  // Counter, direction and active mode registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= {R_SIZE{1'b0}};
      dir_down <= 1'b0;
      act_mode <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      dir_down <= dir_down_n;
      if (boundary) act_mode <= mode;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  // Next count: edge-aligned only, wrapping after P.
  always_comb begin
    cnt_n = cnt;
    if (!enable || (eff_p == {R_SIZE{1'b0}})) begin
      cnt_n = {R_SIZE{1'b0}};
    end else if (cnt == eff_p) begin
      cnt_n = {R_SIZE{1'b0}};
    end else begin
      cnt_n = cnt + R_SIZE'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {R_SIZE{1'b0}};
    end else begin
      cnt <= cnt_n;
    end
  end
`endif

  // Per-channel compare against the duty that governs the current period.
  always_comb begin
    pwm_n = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      pwm_n[i] = enable && (cnt < (boundary ? shd_duty[i] : act_duty[i]));
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm         <= {CH{1'b0}};
      cycle_start <= 1'b0;
    end else begin
      pwm         <= pwm_n;
      cycle_start <= boundary;
    end
  end

endmodule

// File: doc/pwm_array.md
PWM_ARRAY -- requirements
Module: pwm_array

Interface
REQ-001 The block SHALL take parameter R_SIZE, default 8: counter, duty and period width in bits.
REQ-002 The block SHALL take parameter CH, default 4: number of independent PWM channels, range 1..16.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port enable, input, 1 bit: run (1) or hold (0).
REQ-006 The block SHALL have port load, input, 1 bit: write strobe; duty is written to the shadow register of channel ch_sel.
REQ-007 The block SHALL have port ch_sel, input, max(1,$clog2(CH)) bits: channel index for load; values >= CH are ignored.
REQ-008 The block SHALL have port duty, input, R_SIZE bits: duty value written on load.
REQ-009 The block SHALL have port load_period, input, 1 bit: strobe that writes period to the period shadow register.
REQ-010 The block SHALL have port period, input, R_SIZE bits: terminal count P.
REQ-011 The block SHALL have port mode, input, 1 bit: 0 = edge-aligned, 1 = center-aligned; sampled at the period boundary.
REQ-012 The block SHALL have port pwm, output, CH bits: registered PWM outputs.
REQ-013 The block SHALL have port cycle_start, output, 1 bit: one-cycle pulse marking the start of each period.

Function
REQ-014 The shared counter SHALL run while enable=1; edge mode counts 0..P then wraps to 0, giving P+1 cycles per period.
REQ-015 Center mode SHALL count up 0..P, then down P-1..1, then 0, giving 2P cycles per period; a direction flag SHALL be held in a register.
REQ-016 If P=0, the counter SHALL hold at 0 and every cycle SHALL be a period boundary.
REQ-017 A period boundary SHALL be the cycle in which the counter returns to 0, or the first enabled cycle after reset or after enable rises.
REQ-018 At a boundary, active duty[i] SHALL be updated from shadow[i], active P from the period shadow, and active mode from mode, all together; no change is allowed mid-period.
REQ-019 pwm[i] SHALL be registered: 1 when count < active duty[i], else 0; output latency SHALL be 1 cycle after the counter value.
REQ-020 Duty 0 SHALL hold pwm[i] low for the full period.
REQ-021 Edge mode: a duty of P+1 or more SHALL hold pwm[i] high for the full period.
REQ-022 Center mode: a duty D with 1<=D<=P SHALL give 2D-1 high cycles per period; D>P SHALL hold pwm[i] high for the full period.
REQ-023 cycle_start SHALL be registered and aligned with the pwm output for count 0 of each new period.
REQ-024 load and load_period asserted in the same cycle SHALL both be accepted.
REQ-025 A load coincident with a boundary SHALL be applied at the next boundary; the active value at the current boundary SHALL be the old shadow.
REQ-026 While enable=0: the counter SHALL hold at 0, pwm SHALL be all 0, cycle_start SHALL be 0, the direction flag SHALL be up, and shadow writes SHALL still be accepted.
REQ-027 Arithmetic SHALL be unsigned R_SIZE bits; the counter SHALL never exceed active P, so no overflow occurs.
REQ-028 If P shrinks below the current count at a boundary, the count SHALL already be 0 at that point, so no special case is needed.

Reset
REQ-029 Asserting rst SHALL immediately clear the counter, the direction flag (up), all active and shadow duties, the active and shadow period, the active mode, pwm, and cycle_start.
REQ-030 Reset mid-period SHALL discard pending shadow writes; the first period after reset release with enable=1 SHALL use the values loaded after reset.

Configuration
REQ-031 With macro PWM_ARRAY_CENTER_EN defined, center-aligned mode SHALL be present as in REQ-015 and REQ-022.
REQ-032 Without PWM_ARRAY_CENTER_EN, the mode input SHALL be ignored, the block SHALL operate in edge mode only, and the direction flag logic SHALL be absent.

Verification
REQ-033 Test: R_SIZE=8, P=9, edge mode, duty ch0=3, enable -> pwm[0] high 3 of every 10 cycles; cycle_start once per 10 cycles.
REQ-034 Test: center mode, P=5, duty 2 -> period 10 cycles with pwm high 3 cycles (counts 1,0,1) centred on count 0; requires PWM_ARRAY_CENTER_EN.
REQ-035 Test: load ch1 duty 7 mid-period, old value 2 -> pwm[1] keeps 2 high cycles until the next cycle_start, then 7.
REQ-036 Test: duty 0 and duty 255 with P=9 -> pwm constantly 0 and constantly 1 respectively; ch_sel=CH -> no channel changes.
REQ-037 Test: assert rst mid-period -> pwm=0 and count=0 in the same cycle; after release with enable=1 and no loads -> pwm remains 0.
REQ-038 Test: deassert enable for 5 cycles mid-period -> pwm=0 and no cycle_start; on re-enable the period restarts at count 0 with a cycle_start pulse.
